// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - accelerator interface types shared by the predecoder responder
package acc_pkg;

   typedef struct packed {
      logic [31:0] q_instr_data;
   } acc_prd_req_t;

   typedef struct packed {
      logic       p_accept;
      logic [1:0] p_writeback;
      logic [2:0] p_use_rs;
   } acc_prd_rsp_t;

   typedef struct packed {
      logic [31:0]  instr_data;
      logic [31:0]  instr_mask;
      acc_prd_rsp_t prd_rsp;
   } offload_instr_t;

   typedef enum logic {PrdEmpty, PrdFull} acc_prd_state_e;

   localparam acc_prd_rsp_t AccPrdRspReject = '0;

endpackage

// File: rtl/acc_prd_match.sv
// rtl/acc_prd_match.sv - combinational offload-table lookup, lowest matching index wins
module acc_prd_match
   import acc_pkg::*;
#(
   parameter int unsigned    NumInstr = 1,
   parameter offload_instr_t OffloadInstr [NumInstr] = '{default: '0}
) (
   input  logic [31:0]  instr_i,
   output acc_prd_rsp_t rsp_o
);

   // Walk from the highest index down so the lowest hit is the last writer.
   always_comb begin
      rsp_o = AccPrdRspReject;
      for (int i = int'(NumInstr) - 1; i >= 0; i--) begin
         if ((instr_i & OffloadInstr[i].instr_mask) ==
             (OffloadInstr[i].instr_data & OffloadInstr[i].instr_mask)) begin
            rsp_o          = OffloadInstr[i].prd_rsp;
            rsp_o.p_accept = 1'b1;
         end
      end
   end

endmodule

// File: rtl/acc_predecoder_rsp.sv
// rtl/acc_predecoder_rsp.sv - predecoder responder: one-entry response register, optional ACC_PRD_STATS_EN counters
module acc_predecoder_rsp
   import acc_pkg::*;
#(
   parameter int unsigned    NumInstr = 1,
   parameter offload_instr_t OffloadInstr [NumInstr] = '{default: '0},
   parameter int unsigned    CntWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  acc_prd_req_t        prd_req_i,
   input  logic                prd_q_valid_i,
   output logic                prd_q_ready_o,
   output acc_prd_rsp_t        prd_rsp_o,
   output logic                prd_p_valid_o,
   input  logic                prd_p_ready_i,
   input  logic                stat_clr_i,
   output logic [CntWidth-1:0] stat_accept_o,
   output logic [CntWidth-1:0] stat_reject_o
);

   acc_prd_state_e state_q, state_d;
   acc_prd_rsp_t   rsp_q, rsp_d;
   acc_prd_rsp_t   match_rsp;
   logic           req_fire;
   logic           rsp_fire;

   acc_prd_match #(
      .NumInstr     (NumInstr),
      .OffloadInstr (OffloadInstr)
   ) u_match (
      .instr_i (prd_req_i.q_instr_data),
      .rsp_o   (match_rsp)
   );

   assign prd_q_ready_o = (state_q == PrdEmpty) | prd_p_ready_i;
   assign req_fire      = prd_q_valid_i & prd_q_ready_o;
   assign rsp_fire      = (state_q == PrdFull) & prd_p_ready_i;
   assign prd_p_valid_o = (state_q == PrdFull);
   assign prd_rsp_o     = rsp_q;

   // The register is cleared on drain so the output reads zero while empty.
   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      if (req_fire) begin
         state_d = PrdFull;
         rsp_d   = match_rsp;
      end else if (rsp_fire) begin
         state_d = PrdEmpty;
         rsp_d   = AccPrdRspReject;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= PrdEmpty;
         rsp_q   <= AccPrdRspReject;
      end else begin
         state_q <= state_d;
         rsp_q   <= rsp_d;
      end
   end

`ifdef ACC_PRD_STATS_EN
   logic [CntWidth-1:0] accept_q, accept_d;
   logic [CntWidth-1:0] reject_q, reject_d;

   always_comb begin
      accept_d = accept_q;
      reject_d = reject_q;
      if (stat_clr_i) begin
         accept_d = '0;
         reject_d = '0;
      end else if (req_fire) begin
         if (match_rsp.p_accept) begin
            if (accept_q != '1) accept_d = accept_q + 1'b1;
         end else begin
            if (reject_q != '1) reject_d = reject_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         accept_q <= '0;
         reject_q <= '0;
      end else begin
         accept_q <= accept_d;
         reject_q <= reject_d;
      end
   end

   assign stat_accept_o = accept_q;
   assign stat_reject_o = reject_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr_i;
   assign stat_accept_o   = '0;
   assign stat_reject_o   = '0;
`endif

endmodule

// File: tb/tb_acc_predecoder_rsp.sv
// tb/tb_acc_predecoder_rsp.sv - directed self-checking bench for acc_predecoder_rsp
module tb_acc_predecoder_rsp;
   import acc_pkg::*;

`ifdef ACC_PRD_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   localparam offload_instr_t TblA [2] = '{
      '{32'h0000002B, 32'h0000707F, 6'b0_01_011},
      '{32'h0000102B, 32'h0000707F, 6'b0_00_001}
   };
   localparam offload_instr_t TblW [2] = '{
      '{32'h0000002B, 32'h00000000, 6'b0_01_011},
      '{32'h0000102B, 32'h0000707F, 6'b0_00_001}
   };

   logic         clk = 1'b0;
   logic         rst_n;
   acc_prd_req_t req;
   logic         q_valid;
   logic         p_ready;
   logic         clr;

   logic         q_ready, p_valid, w_q_ready, w_p_valid;
   acc_prd_rsp_t rsp, w_rsp;
   logic [1:0]   st_acc, st_rej;
   logic [31:0]  w_st_acc, w_st_rej;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   acc_predecoder_rsp #(.NumInstr(2), .OffloadInstr(TblA), .CntWidth(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .prd_req_i(req), .prd_q_valid_i(q_valid),
      .prd_q_ready_o(q_ready), .prd_rsp_o(rsp), .prd_p_valid_o(p_valid),
      .prd_p_ready_i(p_ready), .stat_clr_i(clr),
      .stat_accept_o(st_acc), .stat_reject_o(st_rej)
   );

   acc_predecoder_rsp #(.NumInstr(2), .OffloadInstr(TblW), .CntWidth(32)) dut_w (
      .clk_i(clk), .rst_ni(rst_n), .prd_req_i(req), .prd_q_valid_i(q_valid),
      .prd_q_ready_o(w_q_ready), .prd_rsp_o(w_rsp), .prd_p_valid_o(w_p_valid),
      .prd_p_ready_i(p_ready), .stat_clr_i(clr),
      .stat_accept_o(w_st_acc), .stat_reject_o(w_st_rej)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] st(input int v);
      return StatsEn ? 32'(v) : 32'd0;
   endfunction

   initial begin
      rst_n = 1'b0; q_valid = 1'b0; p_ready = 1'b1; clr = 1'b0;
      req = '0;
      step(); step();
      chk("rst_p_valid", 32'(p_valid), 32'd0);
      chk("rst_rsp", 32'(rsp), 32'd0);
      chk("rst_stat_acc", 32'(st_acc), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_q_ready", 32'(q_ready), 32'd1);
      chk("idle_p_valid", 32'(p_valid), 32'd0);

      // single hit
      req = 32'h00A5802B; q_valid = 1'b1;
      step();
      q_valid = 1'b0; #1;
      chk("hit_p_valid", 32'(p_valid), 32'd1);
      chk("hit_rsp", 32'(rsp), 32'h2B);
      step();
      chk("hit_drain_valid", 32'(p_valid), 32'd0);
      chk("hit_drain_rsp", 32'(rsp), 32'd0);

      // miss
      req = 32'h00A5202B; q_valid = 1'b1;
      step();
      q_valid = 1'b0; #1;
      chk("miss_p_valid", 32'(p_valid), 32'd1);
      chk("miss_rsp", 32'(rsp), 32'd0);
      step();
      chk("miss_drain_valid", 32'(p_valid), 32'd0);
      chk("miss_stat_rej", 32'(st_rej), st(1));
      chk("miss_stat_acc", 32'(st_acc), st(1));

      // back-pressure
      p_ready = 1'b0; req = 32'h0000102B; q_valid = 1'b1;
      step();
      q_valid = 1'b0; #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_p_valid", 32'(p_valid), 32'd1);
         chk("bp_rsp", 32'(rsp), 32'h21);
         chk("bp_q_ready", 32'(q_ready), 32'd0);
         step();
      end
      p_ready = 1'b1; #1;
      chk("bp_release_q_ready", 32'(q_ready), 32'd1);
      chk("bp_release_rsp", 32'(rsp), 32'h21);
      step();
      chk("bp_consumed_once", 32'(p_valid), 32'd0);

      // streaming
      req = 32'h0000002B; q_valid = 1'b1;
      step();
      req = 32'h0000102B; #1;
      chk("str0_rsp", 32'(rsp), 32'h2B);
      chk("str0_q_ready", 32'(q_ready), 32'd1);
      step();
      req = 32'h0000202B; #1;
      chk("str1_rsp", 32'(rsp), 32'h21);
      chk("str1_p_valid", 32'(p_valid), 32'd1);
      chk("wild_rsp", 32'(w_rsp), 32'h2B);
      chk("str1_q_ready", 32'(q_ready), 32'd1);
      step();
      q_valid = 1'b0; #1;
      chk("str2_rsp", 32'(rsp), 32'd0);
      chk("str2_p_valid", 32'(p_valid), 32'd1);
      chk("wild_miss_rsp", 32'(w_rsp), 32'h2B);
      step();
      chk("str_drain_valid", 32'(p_valid), 32'd0);
      chk("str_stat_acc", 32'(st_acc), st(3));
      chk("str_stat_rej", 32'(st_rej), st(2));
      chk("wild_stat_acc", w_st_acc, st(6));

      // reset while full
      p_ready = 1'b0; req = 32'h0000002B; q_valid = 1'b1;
      step();
      q_valid = 1'b0; #1;
      chk("full_before_rst", 32'(p_valid), 32'd1);
      rst_n = 1'b0;
      step();
      chk("rst_full_p_valid", 32'(p_valid), 32'd0);
      chk("rst_full_rsp", 32'(rsp), 32'd0);
      chk("rst_full_stat", 32'(st_acc), 32'd0);
      rst_n = 1'b1; p_ready = 1'b1;
      step();

      // counter saturation and clear
      req = 32'h0000002B; q_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      q_valid = 1'b0;
      step();
      chk("sat_stat_acc", 32'(st_acc), st(3));
      chk("sat_stat_rej", 32'(st_rej), 32'd0);
      q_valid = 1'b1; clr = 1'b1;
      step();
      q_valid = 1'b0; clr = 1'b0; #1;
      chk("clr_stat_acc", 32'(st_acc), 32'd0);
      chk("clr_p_valid", 32'(p_valid), 32'd1);
      chk("clr_rsp", 32'(rsp), 32'h2B);
      step();
      chk("clr_drain", 32'(p_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
